// File: rtl/ni_inject_arbiter_pkg.sv
// Shared constants for the NI injection arbiter: field sizes, flit layout and FSM encoding.
// Flit layout, MSB first: {parity, header, payload, dest}.
package ni_inject_arbiter_pkg;

  localparam int ADDR_SZ = 4;
  localparam int HDR_SZ  = 4;
  localparam int PL_SZ   = 8;
  localparam int FLIT_W  = HDR_SZ + PL_SZ + ADDR_SZ;

  localparam int FLIT_DEST_LSB = 0;
  localparam int FLIT_PL_LSB   = ADDR_SZ;
  localparam int FLIT_HDR_LSB  = ADDR_SZ + PL_SZ;
  localparam int FLIT_PAR_BIT  = FLIT_W - 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_HOLD = 2'd3
  } arb_state_e;

endpackage

// File: rtl/ni_inject_arbiter_rr_pick.sv
// Round-robin picker: first set request scanning upward from ptr, wrapping at N_SRC.
module ni_inject_arbiter_rr_pick #(
  parameter int N_SRC = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_SRC-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  logic [N_SRC-1:0] rot;

  // Rotate so bit 0 is the source at ptr; the lowest set bit of rot wins.
  assign rot = N_SRC'({req, req} >> ptr);

  always_comb begin
    int sum;
    any = 1'b0;
    idx = '0;
    sum = 0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (rot[k]) begin
        any = 1'b1;
        sum = int'(ptr) + k;
        if (sum >= N_SRC) sum = sum - N_SRC;
        idx = IDX_W'(sum);
      end
    end
  end

endmodule

// File: rtl/ni_inject_arbiter.sv
// NI injection arbiter: round-robin share of one router injection port among N_SRC sources.
// Optional even parity in item_out MSB when NI_ARB_PARITY_EN is defined (otherwise MSB = 0).
//
//  state | meaning
//  IDLE  | waiting for any src_req; registers the round-robin winner
//  LOAD  | captures winner's flit, pulses its grant, drops self-addressed flits
//  SEND  | presents item_out; pulses req on the first cycle channel_busy is low
//  HOLD  | HOLD_CYC quiet cycles before the next arbitration
module ni_inject_arbiter
  import ni_inject_arbiter_pkg::*;
#(
  parameter int N_SRC    = 4,
  parameter int IDX_W    = 2,
  parameter int HOLD_CYC = 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [ADDR_SZ-1:0]            id,
  input  logic [N_SRC-1:0]              src_req,
  input  logic [N_SRC*ADDR_SZ-1:0]      src_dest,
  input  logic [N_SRC*PL_SZ-1:0]        src_payload,
  input  logic [N_SRC*(HDR_SZ-1)-1:0]   src_hdr,
  output logic [N_SRC-1:0]              src_gnt,
  input  logic                          channel_busy,
  output logic                          req,
  output logic [FLIT_W-1:0]             item_out,
  output logic                          busy,
  output logic [15:0]                   sent_cnt,
  output logic [15:0]                   drop_cnt
);

  localparam logic [2:0] HOLD_LD = (HOLD_CYC == 0) ? 3'd0 : 3'(HOLD_CYC - 1);

  arb_state_e          state, state_nxt;
  logic [IDX_W-1:0]    win_idx, rr_ptr, pick_idx;
  logic                pick_any;
  logic [2:0]          hold_cnt;
  logic [ADDR_SZ-1:0]  win_dest;
  logic [PL_SZ-1:0]    win_pl;
  logic [HDR_SZ-2:0]   win_hdr;
  logic                win_self, par;
  logic [FLIT_W-1:0]   flit_nxt;

  ni_inject_arbiter_rr_pick #(.N_SRC(N_SRC), .IDX_W(IDX_W)) u_rr_pick (
    .req (src_req),
    .ptr (rr_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_comb begin
    win_dest = '0;
    win_pl   = '0;
    win_hdr  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (win_idx == IDX_W'(i)) begin
        win_dest = src_dest[i*ADDR_SZ +: ADDR_SZ];
        win_pl   = src_payload[i*PL_SZ +: PL_SZ];
        win_hdr  = src_hdr[i*(HDR_SZ-1) +: (HDR_SZ-1)];
      end
    end
  end

  assign win_self = (win_dest == id);

`ifdef NI_ARB_PARITY_EN
  assign par = ^{win_hdr, win_pl, win_dest};
`else
  assign par = 1'b0;
`endif

  always_comb begin
    flit_nxt = '0;
    flit_nxt[FLIT_DEST_LSB +: ADDR_SZ]  = win_dest;
    flit_nxt[FLIT_PL_LSB +: PL_SZ]      = win_pl;
    flit_nxt[FLIT_HDR_LSB +: HDR_SZ-1]  = win_hdr;
    flit_nxt[FLIT_PAR_BIT]              = par;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (pick_any) state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = win_self ? ST_IDLE : ST_SEND;
      ST_SEND: if (!channel_busy) state_nxt = (HOLD_CYC == 0) ? ST_IDLE : ST_HOLD;
      ST_HOLD: if (hold_cnt == 3'd0) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != ST_IDLE);
    req  = (state == ST_SEND) && !channel_busy;
    for (int i = 0; i < N_SRC; i++) begin
      src_gnt[i] = (state == ST_LOAD) && (win_idx == IDX_W'(i));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win_idx  <= '0;
      rr_ptr   <= '0;
      hold_cnt <= '0;
      item_out <= '0;
      sent_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (state == ST_IDLE && pick_any) win_idx <= pick_idx;
      if (state == ST_LOAD) begin
        item_out <= flit_nxt;
        rr_ptr   <= (win_idx == IDX_W'(N_SRC - 1)) ? '0 : win_idx + 1'b1;
        if (win_self && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
      if (state == ST_SEND && !channel_busy) begin
        hold_cnt <= HOLD_LD;
        if (sent_cnt != 16'hFFFF) sent_cnt <= sent_cnt + 16'd1;
      end
      if (state == ST_HOLD && hold_cnt != 3'd0) hold_cnt <= hold_cnt - 3'd1;
    end
  end

endmodule

// File: tb/tb_ni_inject_arbiter.sv
// Scoreboard bench for ni_inject_arbiter: model predicts grant order and flits per request round.
module tb_ni_inject_arbiter;
  import ni_inject_arbiter_pkg::*;

  localparam int N    = 4;
  localparam int IW   = 2;
  localparam int HOLD = 1;

  logic                       clk, reset_n, channel_busy, req, busy;
  logic [ADDR_SZ-1:0]         id;
  logic [N-1:0]               src_req, src_gnt;
  logic [N*ADDR_SZ-1:0]       src_dest;
  logic [N*PL_SZ-1:0]         src_payload;
  logic [N*(HDR_SZ-1)-1:0]    src_hdr;
  logic [FLIT_W-1:0]          item_out;
  logic [15:0]                sent_cnt, drop_cnt;

  ni_inject_arbiter #(.N_SRC(N), .IDX_W(IW), .HOLD_CYC(HOLD)) dut (
    .clk(clk), .reset_n(reset_n), .id(id), .src_req(src_req), .src_dest(src_dest),
    .src_payload(src_payload), .src_hdr(src_hdr), .src_gnt(src_gnt),
    .channel_busy(channel_busy), .req(req), .item_out(item_out), .busy(busy),
    .sent_cnt(sent_cnt), .drop_cnt(drop_cnt)
  );

  typedef struct {
    int               idx;
    logic [FLIT_W-1:0] flit;
    bit               drop;
  } exp_t;

  exp_t              exp_q[$];
  logic [FLIT_W-1:0] req_q[$];
  int                req_times[$];
  int checks = 0, errors = 0, cyc = 0, last_gnt_cyc = 0;
  int mptr = 0, m_sent = 0, m_drop = 0;
  bit lat_chk = 0, rand_busy = 0;
  logic [ADDR_SZ-1:0] d_dest[N];
  logic [HDR_SZ-2:0]  d_hdr[N];
  logic [PL_SZ-1:0]   d_pl[N];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [FLIT_W-1:0] mk_flit(input logic [HDR_SZ-2:0] h,
                                                 input logic [PL_SZ-1:0] p,
                                                 input logic [ADDR_SZ-1:0] d);
    logic [FLIT_W-2:0] low;
    logic              pb;
    low = {h, p, d};
`ifdef NI_ARB_PARITY_EN
    pb = ($countones(low) % 2) == 1;
`else
    pb = 1'b0;
`endif
    return {pb, low};
  endfunction

  // Monitor: every grant and every req pulse is matched against the model's queues.
  always @(negedge clk) begin : mon
    exp_t              e;
    logic [N-1:0]      eg;
    logic [FLIT_W-1:0] f;
    cyc++;
    if (reset_n) begin
      if (src_gnt != '0) begin
        if (exp_q.size() == 0) chk("gnt_unexpected", 32'(src_gnt), 0);
        else begin
          e = exp_q.pop_front();
          eg = '0;
          eg[e.idx] = 1'b1;
          chk("gnt_onehot", 32'(src_gnt), 32'(eg));
          if (!e.drop) req_q.push_back(e.flit);
          last_gnt_cyc = cyc;
        end
      end
      if (req) begin
        chk("req_while_busy", 32'(channel_busy), 0);
        if (req_q.size() == 0) chk("req_unexpected", 1, 0);
        else begin
          f = req_q.pop_front();
          chk("item_out", 32'(item_out), 32'(f));
          if (lat_chk) chk("gnt_to_req", cyc - last_gnt_cyc, 1);
        end
        req_times.push_back(cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    src_req = src_req & ~src_gnt;
    if (rand_busy) channel_busy = ($urandom_range(0, 99) < 35);
  endtask

  task automatic issue_round(input logic [N-1:0] mask);
    exp_t e;
    int   last, i;
    last = mptr;
    for (int k = 0; k < N; k++) begin
      i = (mptr + k) % N;
      if (mask[i]) begin
        e.idx  = i;
        e.flit = mk_flit(d_hdr[i], d_pl[i], d_dest[i]);
        e.drop = (d_dest[i] == id);
        exp_q.push_back(e);
        if (e.drop) m_drop++; else m_sent++;
        last = i;
      end
    end
    if (mask != '0) mptr = (last + 1) % N;
    for (int s = 0; s < N; s++) begin
      src_dest[s*ADDR_SZ +: ADDR_SZ]         = d_dest[s];
      src_payload[s*PL_SZ +: PL_SZ]          = d_pl[s];
      src_hdr[s*(HDR_SZ-1) +: (HDR_SZ-1)]    = d_hdr[s];
    end
    src_req = src_req | mask;
  endtask

  task automatic wait_round();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || req_q.size() != 0 || busy || src_req != '0) && n < 400) begin
      step();
      n++;
    end
    if (rand_busy) channel_busy = 1'b0;
    chk("round_timeout", 32'(n < 400), 1);
    if (n >= 400) begin
      exp_q.delete();
      req_q.delete();
    end
    chk("sent_cnt", 32'(sent_cnt), m_sent);
    chk("drop_cnt", 32'(drop_cnt), m_drop);
  endtask

  task automatic rand_data(input logic [N-1:0] self_mask);
    for (int s = 0; s < N; s++) begin
      d_hdr[s]  = HDR_SZ'($urandom) ;
      d_pl[s]   = PL_SZ'($urandom);
      d_dest[s] = self_mask[s] ? id : id ^ ADDR_SZ'($urandom_range(1, 15));
    end
  endtask

  initial begin
    logic [FLIT_W-1:0] snap;
    int n;
    reset_n = 1'b0; channel_busy = 1'b0; id = '0; src_req = '0;
    src_dest = '0; src_payload = '0; src_hdr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_item_out", 32'(item_out), 0);
    chk("rst_req", 32'(req), 0);
    chk("rst_gnt", 32'(src_gnt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_sent", 32'(sent_cnt), 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    step();

    // single source, dest 1, id 0
    lat_chk = 1;
    id = 4'd0;
    rand_data('0);
    d_dest[0] = 4'd1;
    issue_round(4'b0001);
    wait_round();
    chk("t1_dest_field", 32'(item_out[ADDR_SZ-1:0]), 1);
    chk("t1_sent", 32'(sent_cnt), 1);

    // all four held, back-to-back spacing
    req_times.delete();
    rand_data('0);
    issue_round(4'b1111);
    wait_round();
    chk("t2_req_count", req_times.size(), 4);
    for (int j = 1; j < req_times.size(); j++)
      chk("t2_req_spacing", req_times[j] - req_times[j-1], 3 + HOLD);

    // channel busy for 10 cycles
    lat_chk = 0;
    rand_data('0);
    channel_busy = 1'b1;
    issue_round(4'b1000);
    n = 0;
    while (src_gnt == '0 && n < 20) begin step(); n++; end
    chk("t3_gnt_seen", 32'(n < 20), 1);
    step();
    snap = item_out;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      chk("t3_req_low", 32'(req), 0);
      chk("t3_item_stable", 32'(item_out), 32'(snap));
      step();
    end
    channel_busy = 1'b0;
    @(negedge clk);
    chk("t3_req_first_free", 32'(req), 1);
    wait_round();

    // self-addressed flit on source 2
    lat_chk = 1;
    id = 4'd5;
    rand_data(4'b0100);
    issue_round(4'b0100);
    wait_round();
    chk("t4_drop", 32'(drop_cnt), 1);

    // parity: payload 1, other fields 0
    id = 4'd1;
    rand_data('0);
    d_dest[1] = 4'd0; d_hdr[1] = '0; d_pl[1] = 8'h01;
    issue_round(4'b0010);
    wait_round();
`ifdef NI_ARB_PARITY_EN
    chk("t6_parity_msb", 32'(item_out[FLIT_W-1]), 1);
`else
    chk("t6_parity_msb", 32'(item_out[FLIT_W-1]), 0);
`endif

    // randomized rounds with random channel backpressure and self-addressed flits
    lat_chk = 0;
    rand_busy = 1;
    for (int r = 0; r < 30; r++) begin
      id = ADDR_SZ'($urandom);
      rand_data(N'($urandom_range(0, 15) & $urandom_range(0, 15)));
      issue_round(N'($urandom_range(1, 15)));
      wait_round();
    end
    rand_busy = 0;
    channel_busy = 1'b0;

    // async reset while in SEND
    id = 4'd3;
    rand_data('0);
    channel_busy = 1'b1;
    issue_round(4'b0100);
    n = 0;
    while (src_gnt == '0 && n < 20) begin step(); n++; end
    chk("t5_gnt_seen", 32'(n < 20), 1);
    step();
    channel_busy = 1'b0;
    #1;
    chk("t5_req_before_rst", 32'(req), 1);
    reset_n = 1'b0;
    #1;
    chk("t5_rst_req", 32'(req), 0);
    chk("t5_rst_gnt", 32'(src_gnt), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    chk("t5_rst_sent", 32'(sent_cnt), 0);
    chk("t5_rst_drop", 32'(drop_cnt), 0);
    exp_q.delete();
    req_q.delete();
    mptr = 0; m_sent = 0; m_drop = 0;
    src_req = '0;
    step();
    step();
    reset_n = 1'b1;
    step();
    lat_chk = 1;
    rand_data('0);
    issue_round(4'b1111);
    wait_round();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
